unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Parametrised single-port memory front end that lets the processor's instruction-fetch port and data port share one synchronous-read memory. It sits between the processor and a unified code/data memory and replaces the split IM/DM hookup. It adds:
- a request/acknowledge handshake per port,
- round-robin arbitration on conflicts,
- configurable memory read latency (wait states).

## Interface
Parameters:
- ADDR_W, 7, word-address width of both ports and the memory.
- DATA_W, 32, data word width.
- WAIT_STATES, 1, memory read latency in cycles from the enable edge; legal range 1..15.

Ports:
- sysclk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- im_req  in  1  fetch request; held high until im_ack.
- im_addr  in  ADDR_W  fetch address; stable while im_req is high.
- im_rdata  out  DATA_W  fetched word; valid in the im_ack cycle.
- im_ack  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data; valid in the dm_ack cycle.
- dm_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: every output is 0; the last-grant register is IM and the wait counter is 0.
- IDLE:
  - If any request is pending, latch the grant, address, we and wdata, then go to ACCESS.
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins. The first conflict after reset therefore goes to DM.
- ACCESS lasts exactly WAIT_STATES cycles.
  - mem_en, mem_addr and mem_we are registered and driven in the first ACCESS cycle only.
  - mem_din is driven in the first ACCESS cycle only; it is 0 otherwise.
  - IM grants always force mem_we = 0.
- RESP lasts one cycle. mem_dout is sampled at its closing edge into the granted port's rdata register.
- Next cycle:
  - The granted port's ack is 1 and the state is back in IDLE.
  - The last-grant register is updated to the granted port.
- Writes follow the same sequence. The write port's rdata register holds its previous value.
- The other port's rdata never changes.
- In the ack cycle, the acked port's req is ignored, because the requester is still dropping it. The other port's pending req is arbitrated normally in that cycle.
- If req drops mid-transaction (a protocol violation), the transaction still completes and ack still pulses.
- If rst asserts at any point, outputs clear immediately, the FSM goes to IDLE and no ack is issued for the aborted transaction.

## Timing
- Cycle 0 is the first IDLE cycle in which the req is seen.
- Memory enable: cycle 1.
- RESP: cycle WAIT_STATES+1.
- ack: cycle WAIT_STATES+2.
- Latency from req to ack is WAIT_STATES+2 cycles for both reads and writes.
- Back-to-back throughput is one transaction per WAIT_STATES+2 cycles. The IDLE/ack cycle overlaps the next grant.
- The waiting port sees its req held for at most one extra transaction, i.e. 2·(WAIT_STATES+2) cycles worst case.
- The wait counter is 4 bits wide. It loads WAIT_STATES−1 on entry to ACCESS and leaves ACCESS at 0 without wrapping.

## Configuration
- UMA_CONFLICT_CNT_EN defined:
  - Adds output conflict_cnt (16 bits, reset 0).
  - It increments in every IDLE cycle where both ports have a pending, non-ignored request.
  - It saturates at 0xFFFF and is cleared only by rst.
- UMA_CONFLICT_CNT_EN undefined: the port and its counter logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: hold rst=0 mid-run, then release → all outputs are 0 and the first request is served with normal latency.
- DM write/read, WAIT_STATES=1:
  - Write addr 5 = 0xDEADBEEF → dm_ack in cycle 3 with mem_we=1 only in cycle 1.
  - Then read addr 5 → dm_ack in cycle 3 with dm_rdata=0xDEADBEEF.
- IM fetch, WAIT_STATES=3: im_req, addr 0x12 → mem_en high only in cycle 1, im_ack in cycle 5, im_rdata equals the memory contents; dm_rdata unchanged.
- Conflict after reset: both req in the same cycle → DM is acked first and IM is acked WAIT_STATES+2 cycles later. Repeating the conflict alternates the winner (IM next, since DM won last).
- Reset abort: rst asserted during ACCESS of a DM write → no dm_ack, mem_en=0 at once. After release, a new IM fetch completes normally.
- With UMA_CONFLICT_CNT_EN defined: 10 conflict IDLE cycles → conflict_cnt=10. Preloading near the limit and forcing more conflicts → the count holds at 0xFFFF.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the processor's IM/DM ports, the arbiter and the
// unified code/data memory. The slave modport is the arbiter's view; the
// master modport is the processor+memory side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_rdata;
  logic              im_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    output im_rdata, im_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_din
  );

  modport master (
    output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_dout,
    input  im_rdata, im_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port memory front end shared by instruction fetch (IM) and data (DM).
// Round-robin arbitration on conflicts, WAIT_STATES cycles of read latency.
// Optional feature: define UMA_CONFLICT_CNT_EN to add the 16-bit saturating
// conflict_cnt output.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic sysclk,
  input  logic rst,
  unified_mem_arbiter_if.slave bus
`ifdef UMA_CONFLICT_CNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic              last_im;
  logic              gnt_dm;
  logic              lat_we;
  logic [3:0]        wait_cnt;

  logic              im_v, dm_v, start, sel_dm;

  logic              mem_en_d, mem_we_d, im_ack_d, dm_ack_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_din_d;

  logic              mem_en_q, mem_we_q, im_ack_q, dm_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q, im_rdata_q, dm_rdata_q;

  // A port's req is ignored in its own ack cycle while the requester drops it.
  assign im_v   = bus.im_req & ~im_ack_q;
  assign dm_v   = bus.dm_req & ~dm_ack_q;
  assign start  = (state == IDLE) & (im_v | dm_v);
  // DM wins alone, or on a conflict when IM was granted last.
  assign sel_dm = dm_v & (~im_v | last_im);

  // State register.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (im_v | dm_v) state_d = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    mem_en_d   = start;
    mem_we_d   = start & sel_dm & bus.dm_we;
    mem_addr_d = '0;
    mem_din_d  = '0;
    if (start) begin
      mem_addr_d = sel_dm ? bus.dm_addr : bus.im_addr;
      if (sel_dm) mem_din_d = bus.dm_wdata;
    end
    im_ack_d = (state == RESP) & ~gnt_dm;
    dm_ack_d = (state == RESP) & gnt_dm;
  end

  // Grant latch, wait counter, memory strobes, read data and acks.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      last_im    <= 1'b1;
      gnt_dm     <= 1'b0;
      lat_we     <= 1'b0;
      wait_cnt   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      im_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      im_ack_q   <= im_ack_d;
      dm_ack_q   <= dm_ack_d;
      if (start) begin
        gnt_dm   <= sel_dm;
        lat_we   <= sel_dm & bus.dm_we;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == RESP) begin
        last_im <= ~gnt_dm;
        if (!lat_we) begin
          if (gnt_dm) dm_rdata_q <= bus.mem_dout;
          else        im_rdata_q <= bus.mem_dout;
        end
      end
    end
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.im_ack   = im_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.im_rdata = im_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;

`ifdef UMA_CONFLICT_CNT_EN
  logic [15:0] cnt_q;

  // Count IDLE cycles where both ports have a live request; saturate.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (state == IDLE && im_v && dm_v && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 16'd1;
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a behavioural memory and a
// transaction-level reference of memory contents and round-robin order.
module tb_unified_mem_arbiter;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int WS  = 3;
  localparam int LAT = WS + 2;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            issue;
    int            exact;
  } txn_t;

  logic sysclk = 1'b0;
  logic rst    = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;

  txn_t im_q[$];
  txn_t dm_q[$];

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef UMA_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .sysclk(sysclk),
    .rst(rst),
    .bus(bus)
`ifdef UMA_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'h1000_0000 ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  function automatic void chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural synchronous memory: read data appears WS cycles after the enable edge.
  logic [DW-1:0] mem [128];
  bit            wr  [128];
  logic [DW-1:0] rd_pipe [WS];
  always @(posedge sysclk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_din;
      wr[bus.mem_addr]  <= 1'b1;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we)
                  ? (wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(int'(bus.mem_addr)))
                  : 32'hBAD0_BAD0;
    for (int i = 1; i < WS; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_dout = rd_pipe[WS-1];

  // Reference contents as the processor expects them.
  logic [DW-1:0] ref_mem [128];

  // Monitor state.
  int            en_seen = 0;
  int            en_cyc  = 0;
  bit            en_we   = 0;
  logic [AW-1:0] en_addr = '0;
  logic [DW-1:0] en_din  = '0;
  logic [DW-1:0] im_shadow = '0;
  logic [DW-1:0] dm_shadow = '0;
  bit            last_dm = 0;

  task automatic check_ack(input bit is_dm);
    txn_t t;
    int   lat;
    string nm;
    nm = is_dm ? "dm" : "im";
    if ((is_dm && dm_q.size() == 0) || (!is_dm && im_q.size() == 0)) begin
      chk_eq({nm, "_unexpected_ack"}, 1, 0);
      return;
    end
    t   = is_dm ? dm_q.pop_front() : im_q.pop_front();
    lat = cyc - t.issue;
    if (t.exact > 0) chk_eq({nm, "_latency"}, lat, t.exact);
    else             chk_eq({nm, "_latency_in_range"}, (lat >= LAT && lat <= 2 * LAT), 1);
    chk_eq({nm, "_one_enable"}, en_seen, 1);
    chk_eq({nm, "_en_to_ack"}, cyc - en_cyc, WS + 1);
    chk_eq({nm, "_mem_we"}, en_we, t.we);
    chk_eq({nm, "_mem_addr"}, en_addr, t.addr);
    if (t.we) chk_eq({nm, "_mem_din"}, en_din, t.wdata);
    if (!t.we) begin
      if (is_dm) dm_shadow = t.rdata;
      else       im_shadow = t.rdata;
    end
    en_seen = 0;
    last_dm = is_dm;
  endtask

  always @(negedge sysclk) begin
    if (!rst) begin
      en_seen   = 0;
      im_shadow = '0;
      dm_shadow = '0;
      last_dm   = 0;
    end else begin
      if (bus.mem_en) begin
        en_seen++;
        en_cyc  = cyc;
        en_we   = bus.mem_we;
        en_addr = bus.mem_addr;
        en_din  = bus.mem_din;
      end else begin
        chk_eq("mem_idle_bus", {bus.mem_we, bus.mem_addr, bus.mem_din}, '0);
      end
      if (bus.im_ack) check_ack(0);
      if (bus.dm_ack) check_ack(1);
      chk_eq("im_rdata", bus.im_rdata, im_shadow);
      chk_eq("dm_rdata", bus.dm_rdata, dm_shadow);
    end
  end

  task automatic run_txn(input bit is_dm, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int exact, input bit drop_early);
    txn_t t;
    bit   got;
    got = 0;
    @(posedge sysclk); #1;
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.im_req = 1'b1; bus.im_addr = addr;
    end
    t.we = we; t.addr = addr; t.wdata = wdata; t.issue = cyc; t.exact = exact;
    t.rdata = we ? '0 : ref_mem[addr];
    if (we) ref_mem[addr] = wdata;
    if (is_dm) dm_q.push_back(t);
    else       im_q.push_back(t);
    for (int i = 0; i < 4 * LAT + 4 && !got; i++) begin
      @(negedge sysclk);
      if (drop_early && i == 1) begin
        if (is_dm) bus.dm_req = 1'b0;
        else       bus.im_req = 1'b0;
      end
      got = is_dm ? bus.dm_ack : bus.im_ack;
    end
    if (!got) begin
      chk_eq(is_dm ? "dm_ack_timeout" : "im_ack_timeout", 0, 1);
      if (is_dm) void'(dm_q.pop_back());
      else       void'(im_q.pop_back());
    end
    @(posedge sysclk); #1;
    if (is_dm) bus.dm_req = 1'b0;
    else       bus.im_req = 1'b0;
  endtask

  // Both ports request in the same IDLE cycle; winner is the port not served last.
  task automatic conflict(input logic [AW-1:0] ia, input logic [AW-1:0] da, input bit dwe);
    bit dm_wins;
    logic [DW-1:0] wd;
    dm_wins = !last_dm;
    wd = $urandom;
    fork
      run_txn(0, 0, ia, '0, dm_wins ? 2 * LAT : LAT, 0);
      run_txn(1, dwe, da, wd, dm_wins ? LAT : 2 * LAT, 0);
    join
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_eq({tag, "_im_ack"},   bus.im_ack, 0);
    chk_eq({tag, "_dm_ack"},   bus.dm_ack, 0);
    chk_eq({tag, "_im_rdata"}, bus.im_rdata, 0);
    chk_eq({tag, "_dm_rdata"}, bus.dm_rdata, 0);
    chk_eq({tag, "_mem_en"},   bus.mem_en, 0);
    chk_eq({tag, "_mem_we"},   bus.mem_we, 0);
    chk_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk_eq({tag, "_mem_din"},  bus.mem_din, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.im_req = 0; bus.im_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    for (int a = 0; a < 128; a++) ref_mem[a] = init_val(a);
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b1;
    @(negedge sysclk);
    check_outputs_zero("reset");

    // Directed: DM write then read of address 5, then IM fetch of 0x12.
    run_txn(1, 1, 7'd5, 32'hDEAD_BEEF, LAT, 0);
    run_txn(1, 0, 7'd5, '0, LAT, 0);
    run_txn(0, 0, 7'h12, '0, LAT, 0);
    // Request dropped mid-transaction still completes.
    run_txn(1, 0, 7'd70, '0, LAT, 1);

    // Conflicts: first goes to DM after reset, order follows last grant.
    conflict(7'd3, 7'd80, 1);
    conflict(7'd4, 7'd80, 0);
    run_txn(1, 0, 7'd81, '0, LAT, 0);
    conflict(7'd9, 7'd82, 0);

    // Reset abort during ACCESS of a DM write.
    @(posedge sysclk); #1;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 7'd100; bus.dm_wdata = 32'hCAFE_F00D;
    repeat (2) @(posedge sysclk);
    #1;
    ref_mem[100] = 32'hCAFE_F00D;
    rst = 1'b0;
    #1;
    check_outputs_zero("abort");
    repeat (3) begin
      @(negedge sysclk);
      chk_eq("abort_no_dm_ack", bus.dm_ack, 0);
    end
    bus.dm_req = 0;
    @(posedge sysclk); #1 rst = 1'b1;
    @(negedge sysclk);
    check_outputs_zero("post_abort");
    run_txn(0, 0, 7'd33, '0, LAT, 0);
    run_txn(1, 0, 7'd100, '0, LAT, 0);

`ifdef UMA_CONFLICT_CNT_EN
    for (int k = 0; k < 10; k++) conflict(7'(k), 7'(90 + k), 0);
    @(negedge sysclk);
    chk_eq("conflict_cnt_10", conflict_cnt, 10);
    force dut.cnt_q = 16'hFFFD;
    @(posedge sysclk); #1;
    release dut.cnt_q;
    for (int k = 0; k < 4; k++) conflict(7'(k + 20), 7'(110 + k), 1);
    @(negedge sysclk);
    chk_eq("conflict_cnt_sat", conflict_cnt, 16'hFFFF);
`endif

    // Random concurrent traffic: IM fetches code region, DM uses data region.
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge sysclk);
          run_txn(0, 0, 7'($urandom_range(0, 63)), '0, -1, 0);
        end
      end
      begin
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(posedge sysclk);
          run_txn(1, 1'($urandom_range(0, 1)), 7'($urandom_range(64, 127)), $urandom, -1, 0);
        end
      end
    join

    repeat (4) @(negedge sysclk);
    chk_eq("im_queue_empty", im_q.size(), 0);
    chk_eq("dm_queue_empty", dm_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
